csa_pipe: RTL and testbench

Parametrised, pipelined carry-select adder that computes `a + b + cin` for `WIDTH`-bit operands, one `BLOCK`-bit slice per pipeline stage. It is the successor to the single-bit `full_adder` in the carry-select adder datapath. It adds configurable width, block size, streaming valid/ready handshakes with backpressure, and carry and signed-overflow outputs. It is fully synchronous to one clock and sits between operand producers and any consumer of sums.

---
 rtl/csa_pipe.sv | 179 +++++++++++++++++
 tb/tb_csa_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe.sv
// -----------------------------------------------------------------------------
// csa_pipe
// Pipelined carry-select adder: o_sum = (i_a + i_b + i_cin) mod 2^WIDTH.
// One BLOCK-bit slice is resolved per pipeline stage, so there are
// NBLK = WIDTH/BLOCK stages and the latency is NBLK cycles. Each stage runs
// two ripple chains over its slice, one assuming carry-in 0 and one assuming
// carry-in 1. It then picks one using the carry registered by the previous
// stage.
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rst        asynchronous active-high reset
//   i_in_valid   operand set present
//   o_in_ready   stage 0 can accept operands (combinational, = advance)
//   i_a, i_b     WIDTH-bit operands (unsigned or two's complement)
//   i_cin        carry in
//   o_out_valid  result present (final-stage register)
//   i_out_ready  consumer accepts the result
//   o_sum        sum modulo 2^WIDTH (final-stage register)
//   o_cout       carry out of the MSB (final-stage register)
//   o_ovf        signed overflow (final-stage register)
// -----------------------------------------------------------------------------
module csa_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int NBLK = (BLOCK > 0) ? (WIDTH / BLOCK) : 1;

    if ((BLOCK < 1) || (WIDTH < BLOCK) || ((WIDTH % BLOCK) != 0)) begin : g_param_check
        $fatal(1, "csa_pipe: WIDTH must be a positive multiple of BLOCK");
    end

    // Ripple-carry add of one slice. The result is {carry_out, sum}.
    function automatic logic [BLOCK:0] blk_add(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             c
    );
        logic [BLOCK:0]   cy;
        logic [BLOCK-1:0] s;
        cy[0] = c;
        for (int i = 0; i < BLOCK; i++) begin
            s[i]    = x[i] ^ y[i] ^ cy[i];
            cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
        end
        return {cy[BLOCK], s};
    endfunction

    // The whole pipe moves together. It freezes only while a result waits at the output.
    logic w_adv;
    assign w_adv      = (!o_out_valid) || i_out_ready;
    assign o_in_ready = w_adv;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        // LW: sum bits completed once this stage has resolved its slice.
        // UW: operand bits still unconsumed after this stage.
        localparam int LW = (k + 1) * BLOCK;
        localparam int UW = WIDTH - LW;

        logic [BLOCK-1:0] w_xa;
        logic [BLOCK-1:0] w_xb;
        logic             w_cin;
        logic             w_vin;
        logic [BLOCK:0]   w_r0;
        logic [BLOCK:0]   w_r1;
        logic [BLOCK:0]   w_sel;
        logic [LW-1:0]    w_sum_in;

        logic             r_valid;
        logic             r_carry;
        logic [LW-1:0]    r_sum;

        if (k == 0) begin : g_src
            // Stage 0 resolves its slice straight from the operands being accepted.
            assign w_xa     = i_a[BLOCK-1:0];
            assign w_xb     = i_b[BLOCK-1:0];
            assign w_cin    = i_cin;
            assign w_vin    = i_in_valid;
            assign w_sum_in = w_sel[BLOCK-1:0];
        end else begin : g_src
            // Later stages take their slice from the skewed operand copy held upstream.
            assign w_xa     = g_stage[k-1].g_up.r_ua[BLOCK-1:0];
            assign w_xb     = g_stage[k-1].g_up.r_ub[BLOCK-1:0];
            assign w_cin    = g_stage[k-1].r_carry;
            assign w_vin    = g_stage[k-1].r_valid;
            assign w_sum_in = {w_sel[BLOCK-1:0], g_stage[k-1].r_sum};
        end

        // Both carry hypotheses are evaluated at once. The upstream carry only drives the select.
        assign w_r0  = blk_add(w_xa, w_xb, 1'b0);
        assign w_r1  = blk_add(w_xa, w_xb, 1'b1);
        assign w_sel = w_cin ? w_r1 : w_r0;

        // Stage valid, completed low sum bits and block carry-out.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= {LW{1'b0}};
            end else if (w_adv) begin
                r_valid <= w_vin;
                r_carry <= w_sel[BLOCK];
                r_sum   <= w_sum_in;
            end else begin
                r_valid <= r_valid;
                r_carry <= r_carry;
                r_sum   <= r_sum;
            end
        end

        if (UW > 0) begin : g_up
            logic [UW-1:0] w_ua_in;
            logic [UW-1:0] w_ub_in;
            logic [UW-1:0] r_ua;
            logic [UW-1:0] r_ub;

            if (k == 0) begin : g_usrc
                assign w_ua_in = i_a[WIDTH-1:BLOCK];
                assign w_ub_in = i_b[WIDTH-1:BLOCK];
            end else begin : g_usrc
                assign w_ua_in = g_stage[k-1].g_up.r_ua[UW+BLOCK-1:BLOCK];
                assign w_ub_in = g_stage[k-1].g_up.r_ub[UW+BLOCK-1:BLOCK];
            end

            // Operand bits not yet added travel alongside their partial sum.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_ua <= {UW{1'b0}};
                    r_ub <= {UW{1'b0}};
                end else if (w_adv) begin
                    r_ua <= w_ua_in;
                    r_ub <= w_ub_in;
                end else begin
                    r_ua <= r_ua;
                    r_ub <= r_ub;
                end
            end
        end

        if (k == NBLK - 1) begin : g_last
            // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
            // XOR with the carry out gives the signed overflow.
            logic w_ovf;
            logic r_ovf;
            assign w_ovf = w_xa[BLOCK-1] ^ w_xb[BLOCK-1] ^ w_sel[BLOCK-1] ^ w_sel[BLOCK];

            // Overflow flag is registered with the rest of the final stage.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_ovf;
                end else begin
                    r_ovf <= r_ovf;
                end
            end
        end
    end

    assign o_out_valid = g_stage[NBLK-1].r_valid;
    assign o_sum       = g_stage[NBLK-1].r_sum;
    assign o_cout      = g_stage[NBLK-1].r_carry;
    assign o_ovf       = g_stage[NBLK-1].g_last.r_ovf;

endmodule

// File: tb/tb_csa_pipe.sv
`timescale 1ns/1ps
module tb_csa_pipe;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance: WIDTH=16, BLOCK=4
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    // WIDTH=4, BLOCK=1
    logic        e1_in_valid, e1_in_ready, e1_cin, e1_out_valid, e1_out_ready, e1_cout, e1_ovf;
    logic [3:0]  e1_a, e1_b, e1_sum;

    // WIDTH=4, BLOCK=4
    logic        e4_in_valid, e4_in_ready, e4_cin, e4_out_valid, e4_out_ready, e4_cout, e4_ovf;
    logic [3:0]  e4_a, e4_b, e4_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_pipe #(.WIDTH(16), .BLOCK(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .i_cin(cin), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_sum(sum), .o_cout(cout), .o_ovf(ovf)
    );

    csa_pipe #(.WIDTH(4), .BLOCK(1)) dut_w4b1 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(e1_in_valid), .o_in_ready(e1_in_ready),
        .i_a(e1_a), .i_b(e1_b), .i_cin(e1_cin), .o_out_valid(e1_out_valid), .i_out_ready(e1_out_ready),
        .o_sum(e1_sum), .o_cout(e1_cout), .o_ovf(e1_ovf)
    );

    csa_pipe #(.WIDTH(4), .BLOCK(4)) dut_w4b4 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(e4_in_valid), .o_in_ready(e4_in_ready),
        .i_a(e4_a), .i_b(e4_b), .i_cin(e4_cin), .o_out_valid(e4_out_valid), .i_out_ready(e4_out_ready),
        .o_sum(e4_sum), .o_cout(e4_cout), .o_ovf(e4_ovf)
    );

    // Directed single-operation vectors (hand-computed results)
    logic [15:0] dv_a    [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0FFF, 16'h1234};
    logic [15:0] dv_b    [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h0000, 16'h4321};
    logic        dv_cin  [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    logic [15:0] dv_sum  [5] = '{16'h0000, 16'h8000, 16'h0001, 16'h1000, 16'h5555};
    logic        dv_cout [5] = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
    logic        dv_ovf  [5] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0};

    // Streaming vectors (hand-computed results)
    logic [15:0] st_a    [8] = '{16'h0001, 16'h00FF, 16'h1234, 16'hFFFF, 16'h4000, 16'h8001, 16'hABCD, 16'hF0F0};
    logic [15:0] st_b    [8] = '{16'h0002, 16'h0001, 16'h4321, 16'hFFFF, 16'h4000, 16'hFFFF, 16'h1111, 16'h0F0F};
    logic        st_cin  [8] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1};
    logic [15:0] st_sum  [8] = '{16'h0003, 16'h0100, 16'h5556, 16'hFFFF, 16'h8000, 16'h8000, 16'hBCDE, 16'h0000};
    logic        st_cout [8] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
    logic        st_ovf  [8] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};

    // Drive one operation (out_ready assumed high) and wait, bounded, for its result.
    task automatic apply_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                            output logic [15:0] rs, output logic rc, output logic ro, output int lat);
        @(negedge clk);
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = cout; ro = ovf;
    endtask

    task automatic test_reset;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want 0 0000 0 0",
                     out_valid, sum, cout, ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (e1_out_valid !== 1'b0 || e4_out_valid !== 1'b0 || e1_sum !== 4'h0 || e4_sum !== 4'h0) begin
            errors++;
            $display("FAIL reset_small: got v1=%b v4=%b s1=%h s4=%h want 0 0 0 0",
                     e1_out_valid, e4_out_valid, e1_sum, e4_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_directed;
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            apply_op(dv_a[i], dv_b[i], dv_cin[i], rs, rc, ro, lat);
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat);
            end
            checks++;
            if (rs !== dv_sum[i] || rc !== dv_cout[i] || ro !== dv_ovf[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, rs, rc, ro, dv_sum[i], dv_cout[i], dv_ovf[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int rcv   = 0;
        int first = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (first < 0) first = j;
                checks++;
                if (rcv >= 8) begin
                    errors++;
                    $display("FAIL stream_extra: got result %0d at cycle %0d want only 8", rcv, j);
                end else if (j != 4 + rcv || sum !== st_sum[rcv] || cout !== st_cout[rcv] || ovf !== st_ovf[rcv]) begin
                    errors++;
                    $display("FAIL stream_result[%0d]: got cycle=%0d sum=%h cout=%b ovf=%b want cycle=%0d sum=%h cout=%b ovf=%b",
                             rcv, j, sum, cout, ovf, 4 + rcv, st_sum[rcv], st_cout[rcv], st_ovf[rcv]);
                end
                rcv++;
            end
            if (j < 8) begin
                a = st_a[j]; b = st_b[j]; cin = st_cin[j]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (first != 4 || rcv != 8) begin
            errors++;
            $display("FAIL stream_count: got first=%0d count=%0d want first=4 count=8", first, rcv);
        end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int rcv  = 0;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            out_ready = (j >= 7);
            if (sent < 6) begin
                a = st_a[sent]; b = st_b[sent]; cin = st_cin[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (j == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_empty_ready: got in_ready=%b want 1", in_ready);
                end
            end
            if (j >= 4 && j < 7) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== st_sum[0] || cout !== st_cout[0] || ovf !== st_ovf[0]) begin
                    errors++;
                    $display("FAIL bp_stall[%0d]: got valid=%b in_ready=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                             j, out_valid, in_ready, sum, cout, ovf, st_sum[0], st_cout[0], st_ovf[0]);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (rcv >= 6) begin
                    errors++;
                    $display("FAIL bp_duplicate: got extra result sum=%h want only 6 results", sum);
                end else if (sum !== st_sum[rcv] || cout !== st_cout[rcv] || ovf !== st_ovf[rcv]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             rcv, sum, cout, ovf, st_sum[rcv], st_cout[rcv], st_ovf[rcv]);
                end
                rcv++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcv != 6 || sent != 6) begin
            errors++;
            $display("FAIL bp_count: got sent=%0d received=%0d want 6 6", sent, rcv);
        end
    endtask

    task automatic test_reset_midstream;
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        int          spurious = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            a = st_a[j]; b = st_b[j]; cin = st_cin[j]; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sum !== st_sum[0]) begin
            errors++;
            $display("FAIL rst_mid_pre: got valid=%b sum=%h want 1 %h", out_valid, sum, st_sum[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: got valid=%b sum=%h cout=%b ovf=%b in_ready=%b want 0 0000 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply_op(16'h1111, 16'h2222, 1'b0, rs, rc, ro, lat);
        checks++;
        if (lat != 4 || rs !== 16'h3333 || rc !== 1'b0 || ro !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_first: got lat=%0d sum=%h cout=%b ovf=%b want 4 3333 0 0", lat, rs, rc, ro);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (out_valid === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL rst_mid_flush: got %0d stale results want 0", spurious);
        end
    endtask

    task automatic test_exhaustive_w4b1;
        int         rcv = 0;
        logic [8:0] idx;
        logic [4:0] full;
        logic       exp_ovf;
        for (int j = 0; j < 530; j++) begin
            @(negedge clk);
            if (e1_out_valid === 1'b1) begin
                idx     = rcv[8:0];
                full    = {1'b0, idx[3:0]} + {1'b0, idx[7:4]} + {4'b0000, idx[8]};
                exp_ovf = (idx[3] == idx[7]) && (full[3] != idx[3]);
                checks++;
                if ({e1_ovf, e1_cout, e1_sum} !== {exp_ovf, full}) begin
                    errors++;
                    $display("FAIL w4b1[a=%h b=%h c=%b]: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                             idx[3:0], idx[7:4], idx[8], e1_ovf, e1_cout, e1_sum, exp_ovf, full[4], full[3:0]);
                end
                rcv++;
            end
            if (j < 512) begin
                idx = j[8:0];
                e1_a = idx[3:0]; e1_b = idx[7:4]; e1_cin = idx[8]; e1_in_valid = 1'b1;
            end else begin
                e1_in_valid = 1'b0;
            end
        end
        checks++;
        if (rcv != 512) begin
            errors++;
            $display("FAIL w4b1_count: got %0d want 512", rcv);
        end
    endtask

    task automatic test_exhaustive_w4b4;
        int         rcv = 0;
        logic [8:0] idx;
        logic [4:0] full;
        logic       exp_ovf;
        for (int j = 0; j < 520; j++) begin
            @(negedge clk);
            if (e4_out_valid === 1'b1) begin
                idx     = rcv[8:0];
                full    = {1'b0, idx[3:0]} + {1'b0, idx[7:4]} + {4'b0000, idx[8]};
                exp_ovf = (idx[3] == idx[7]) && (full[3] != idx[3]);
                checks++;
                if ({e4_ovf, e4_cout, e4_sum} !== {exp_ovf, full}) begin
                    errors++;
                    $display("FAIL w4b4[a=%h b=%h c=%b]: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                             idx[3:0], idx[7:4], idx[8], e4_ovf, e4_cout, e4_sum, exp_ovf, full[4], full[3:0]);
                end
                rcv++;
            end
            if (j < 512) begin
                idx = j[8:0];
                e4_a = idx[3:0]; e4_b = idx[7:4]; e4_cin = idx[8]; e4_in_valid = 1'b1;
            end else begin
                e4_in_valid = 1'b0;
            end
        end
        checks++;
        if (rcv != 512) begin
            errors++;
            $display("FAIL w4b4_count: got %0d want 512", rcv);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = 16'h0000; b = 16'h0000; cin = 1'b0;
        e1_in_valid = 1'b0; e1_out_ready = 1'b1; e1_a = 4'h0; e1_b = 4'h0; e1_cin = 1'b0;
        e4_in_valid = 1'b0; e4_out_ready = 1'b1; e4_a = 4'h0; e4_b = 4'h0; e4_cin = 1'b0;
        test_reset;
        test_directed;
        test_back_to_back;
        test_backpressure;
        test_reset_midstream;
        test_exhaustive_w4b1;
        test_exhaustive_w4b4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
